// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, load extraction/extension and
// register-file write-port driver. Also keeps a retired-instruction counter
// and a sticky flag for misaligned or illegal loads.
module writeback_stage #(
  parameter int Width = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_regWrite,
  input  logic             mem_memToReg,
  input  logic [4:0]       mem_rd,
  input  logic [2:0]       mem_funct3,
  input  logic [Width-1:0] mem_aluResult,
  input  logic [Width-1:0] mem_readData,
  output logic             regWrite,
  output logic [4:0]       writeAd,
  output logic [Width-1:0] writeData,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret,
  output logic             load_err
);

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_NONE
  } load_size_e;

  // MEM/WB register fields
  logic             valid_q;
  logic             reg_write_q;
  logic             mem_to_reg_q;
  logic [4:0]       rd_q;
  logic [2:0]       funct3_q;
  logic [Width-1:0] alu_q;
  logic [Width-1:0] rdata_q;

  logic [CNT_W-1:0] instret_q;
  logic             load_err_q;

  // Load decode / extraction
  load_size_e       size;
  logic             zext;
  logic [1:0]       off;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [Width-1:0] load_val;
  logic             misaligned;
  logic             illegal;
  logic             bad;
  logic [Width-1:0] sel_val;

  // Pipeline register capture: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      rd_q         <= '0;
      funct3_q     <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      rd_q         <= '0;
      funct3_q     <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
    end else if (!stall) begin
      valid_q      <= mem_valid;
      reg_write_q  <= mem_regWrite;
      mem_to_reg_q <= mem_memToReg;
      rd_q         <= mem_rd;
      funct3_q     <= mem_funct3;
      alu_q        <= mem_aluResult;
      rdata_q      <= mem_readData;
    end
  end

  // Retire counter: a valid entry retires whenever the register is not stalled
  always_ff @(posedge clk) begin
    if (!rstn) begin
      instret_q <= '0;
    end else if (valid_q && !stall) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  // Sticky error: set the edge after a bad load is present in WB
  always_ff @(posedge clk) begin
    if (!rstn) begin
      load_err_q <= 1'b0;
    end else if (valid_q && bad) begin
      load_err_q <= 1'b1;
    end
  end

  // Decode funct3 into access size and extension mode
  always_comb begin
    size = SZ_NONE;
    zext = 1'b0;
    case (funct3_q)
      3'b000: size = SZ_BYTE;
      3'b100: begin size = SZ_BYTE; zext = 1'b1; end
      3'b001: size = SZ_HALF;
      3'b101: begin size = SZ_HALF; zext = 1'b1; end
      3'b010: size = SZ_WORD;
      default: size = SZ_NONE;
    endcase
  end

  // Pick the addressed byte and half from the little-endian word
  always_comb begin
    off = alu_q[1:0];
    byte_sel = rdata_q[7:0];
    case (off)
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      2'd3: byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  // Extend the extracted field and classify the access
  always_comb begin
    load_val   = rdata_q;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (size)
      SZ_BYTE: begin
        load_val = zext ? {{(Width-8){1'b0}}, byte_sel}
                        : {{(Width-8){byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        load_val = zext ? {{(Width-16){1'b0}}, half_sel}
                        : {{(Width-16){half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      SZ_WORD: begin
        load_val   = rdata_q;
        misaligned = (off != 2'd0);
      end
      default: begin
        load_val = rdata_q;
        illegal  = 1'b1;
      end
    endcase
  end

  // Write-port outputs, driven only from the WB register
  always_comb begin
    bad       = mem_to_reg_q & (misaligned | illegal);
    sel_val   = mem_to_reg_q ? load_val : alu_q;
    wb_valid  = valid_q;
    regWrite  = valid_q & reg_write_q & (rd_q != 5'd0) & ~bad;
    writeAd   = valid_q ? rd_q : '0;
    writeData = valid_q ? sel_val : '0;
    instret   = instret_q;
    load_err  = load_err_q;
  end

endmodule
